// File: rtl/modn_count_monitor.sv
// Watches a mod-N up/down count stream; recovers step/hold/wrap/direction and flags illegal samples.
// Latency 1 (all outputs registered). Optional MODN_MON_REVS_EN adds a signed net revolution counter.
module modn_count_monitor #(
  parameter int N     = 10,
  parameter int REV_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sample_valid,
  input  logic [$clog2(N)-1:0]   count_in,
  input  logic                   err_clr,
  output logic                   locked,
  output logic                   dir_up,
  output logic                   step,
  output logic                   hold,
  output logic                   wrap,
  output logic                   err,
  output logic                   err_sticky,
  output logic [REV_W-1:0]       revs
);

  localparam int W = $clog2(N);
  localparam logic [W-1:0] TOP = W'(N - 1);
  localparam logic [W:0]   MOD = (W + 1)'(N);

  localparam logic [1:0] UNSYNC = 2'd0;
  localparam logic [1:0] ACQ    = 2'd1;
  localparam logic [1:0] TRACK  = 2'd2;

  logic [1:0]   state;
  logic [W-1:0] prev;

  // Neighbours are formed one bit wider so non-power-of-two moduli wrap explicitly.
  logic [W:0]   prev_inc, prev_dec;
  logic [W-1:0] up_val, down_val;
  logic         is_range, is_hold, is_up, is_down, is_jump;
  logic         legal_move, wrap_up, wrap_dn;

  always_comb begin
    prev_inc   = {1'b0, prev} + (W + 1)'(1);
    prev_dec   = {1'b0, prev} - (W + 1)'(1);
    up_val     = (prev == TOP)   ? '0  : prev_inc[W-1:0];
    down_val   = (prev == '0)    ? TOP : prev_dec[W-1:0];
    is_range   = ({1'b0, count_in} >= MOD);
    is_hold    = !is_range && (count_in == prev);
    is_up      = !is_range && (count_in == up_val);
    is_down    = !is_range && (count_in == down_val);
    is_jump    = !is_range && !is_hold && !is_up && !is_down;
    legal_move = sample_valid && (state != UNSYNC) && (is_hold || is_up || is_down);
    wrap_up    = legal_move && is_up   && (prev == TOP);
    wrap_dn    = legal_move && is_down && (prev == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= UNSYNC;
      prev       <= '0;
      locked     <= 1'b0;
      dir_up     <= 1'b1;
      step       <= 1'b0;
      hold       <= 1'b0;
      wrap       <= 1'b0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      step <= 1'b0;
      hold <= 1'b0;
      wrap <= 1'b0;
      err  <= 1'b0;
      if (err_clr) err_sticky <= 1'b0;
      if (sample_valid) begin
        case (state)
          UNSYNC: begin
            if (is_range) begin
              err        <= 1'b1;
              err_sticky <= 1'b1;
            end else begin
              prev  <= count_in;
              state <= ACQ;
            end
          end
          ACQ, TRACK: begin
            if (is_range) begin
              err        <= 1'b1;
              err_sticky <= 1'b1;
              locked     <= 1'b0;
              state      <= UNSYNC;
            end else if (is_jump) begin
              err        <= 1'b1;
              err_sticky <= 1'b1;
              locked     <= 1'b0;
              prev       <= count_in;
              state      <= ACQ;
            end else begin
              // First legal neighbour out of ACQ is reported exactly like a tracked sample.
              state  <= TRACK;
              locked <= 1'b1;
              prev   <= count_in;
              hold   <= is_hold;
              step   <= is_up || is_down;
              wrap   <= wrap_up || wrap_dn;
              if (is_up)   dir_up <= 1'b1;
              if (is_down) dir_up <= 1'b0;
            end
          end
          default: begin
            locked <= 1'b0;
            state  <= UNSYNC;
          end
        endcase
      end
    end
  end

`ifdef MODN_MON_REVS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          revs <= '0;
    else if (wrap_up) revs <= revs + REV_W'(1);
    else if (wrap_dn) revs <= revs - REV_W'(1);
  end
`else
  assign revs = '0;
`endif

endmodule

// File: doc/modn_count_monitor.md
Name: modn_count_monitor

Overview:
- Sits downstream of a mod-N up/down counter and reads its count stream.
- Recovers the direction, step, hold and wrap events from that stream.
- Checks that consecutive samples are legal mod-N neighbours and flags illegal jumps or out-of-range values.
- Optionally tracks net revolutions (signed wrap count) for position/odometry logic.

Parameters:
- N, 10, counter modulus; N >= 3 (N = 2 makes up/down ambiguous; out of scope).
- REV_W, 8, width of revolution counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- sample_valid  in  1  count_in is a new sample this cycle.
- count_in  in  $clog2(N)  observed counter value.
- err_clr  in  1  clears err_sticky.
- locked  out  1  monitor is tracking a legal sequence.
- dir_up  out  1  direction of last step (1 = up).
- step  out  1  one-cycle pulse: legal ±1 step seen.
- hold  out  1  one-cycle pulse: sample equal to previous.
- wrap  out  1  one-cycle pulse: step crossed N-1↔0.
- err  out  1  one-cycle pulse: illegal sample.
- err_sticky  out  1  latched error flag.
- revs  out  REV_W  net wrap count, two's complement.

Behaviour:
- Reset values (async):
  - state = UNSYNC, prev = 0, locked = 0, dir_up = 1.
  - step = hold = wrap = err = 0, err_sticky = 0, revs = 0.
- All outputs are registered. Pulses assert in the cycle after the qualifying sample_valid edge (latency 1).
- Pulses are 0 in every cycle without sample_valid.
- dir_up holds its last value across hold and error samples.
- Classification of a valid sample s against prev:
  - RANGE_ERR: s >= N.
  - HOLD: s == prev.
  - UP: s == (prev == N-1 ? 0 : prev+1).
  - DOWN: s == (prev == 0 ? N-1 : prev-1).
  - JUMP: anything else.
  - Compute prev+1 / prev-1 at $clog2(N)+1 bits; no reliance on natural overflow.
- States:
  - UNSYNC:
    - In-range sample: prev <= s, go to ACQ, no pulses.
    - RANGE_ERR: err pulse, stay in UNSYNC.
  - ACQ:
    - HOLD, UP or DOWN: go to TRACK, locked <= 1, and emit the normal TRACK outputs for this sample.
    - JUMP: err pulse, prev <= s, stay in ACQ.
    - RANGE_ERR: err pulse, go to UNSYNC.
  - TRACK:
    - HOLD: hold pulse.
    - UP: step pulse, dir_up <= 1. If prev == N-1: wrap pulse and revs +1.
    - DOWN: step pulse, dir_up <= 0. If prev == 0: wrap pulse and revs -1.
    - JUMP: err pulse, locked <= 0, prev <= s, go to ACQ.
    - RANGE_ERR: err pulse, locked <= 0, go to UNSYNC, prev unchanged.
  - prev <= s on every legal in-range sample.
- err_sticky:
  - Set by any err pulse. Cleared by err_clr.
  - err_clr in the same cycle as a new error: set wins.
- revs wraps modulo 2^REV_W silently.
- rst mid-stream: immediate return to reset values; the next sample is treated as a first sample.

Optional Feature:
- MODN_MON_REVS_EN defined:
  - revs register implemented as above.
- Not defined:
  - revs port present but tied to 0; no revolution logic synthesized.
  - All other behaviour identical.

Test Plan:
- Lock and count up: after reset, send 3,4,5 → locked = 1 after the 4; step pulses on 4 and 5; dir_up = 1; err = 0.
- Up wrap (N = 10): send 8,9,0,1 → wrap pulse exactly on the 0 sample; dir_up = 1; revs = 1 (feature on) or 0 (feature off).
- Down wrap: send 1,0,9,8 → dir_up = 0 from the 0 sample; wrap pulse on 9; revs = -1 (all ones).
- Hold and gaps: send 5,5 with sample_valid low between samples → one hold pulse, no step; no pulses in invalid cycles.
- Jump then recover: locked at 5, send 8 → err pulse, locked = 0, err_sticky = 1. Then send 9 → relocks with step and dir_up = 1. Then assert err_clr together with an out-of-range 12 → err_sticky stays 1, state UNSYNC.
- Async reset mid-stream: assert rst between two valid samples → all outputs return to reset values without a clock edge; next sample only re-enters ACQ, with no step or err.
